soma_seq_ctrl: RTL and testbench

Sequencing controller for the 4-bit adder/display path on the board. It takes two operands one after the other from the same 4 switches and uses a step button to advance. It computes the 5-bit sum and drives the LED bank and the single 7-segment digit, with overflow shown on the decimal point as a blink. It sits between the board I/O (switches, button) and the LED/SEG outputs of top.

---
 rtl/soma_pkg.sv | 20 ++
 rtl/hex7seg.sv | 11 +
 rtl/soma_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_soma_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/soma_pkg.sv
// Shared types and constants for the 4-bit adder/display sequencer.
// Segment codes are gfedcba, active-high, indexed by the hex digit value.
package soma_pkg;

  localparam int DEF_DATA_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HAVE_A = 2'd1,
    S_ADD    = 2'd2,
    S_SHOW   = 2'd3
  } state_t;

  // Packed so that HEX7[n] selects the code for digit n (last entry is digit 0).
  localparam logic [15:0][6:0] HEX7 = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex digit to 7-segment (gfedcba) lookup.
module hex7seg
  import soma_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segs
);

  assign segs = HEX7[digit];

endmodule

// File: rtl/soma_seq_ctrl.sv
// Two-operand step-driven adder sequencer driving the LED bank and one 7-segment digit.
// All outputs are registered and therefore show the previous cycle's state and data.
module soma_seq_ctrl
  import soma_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int BLINK_HALF = 8
) (
  input  logic              clk_2,
  input  logic              rst_n,
  input  logic              step,
  input  logic              clear,
  input  logic              acc_mode,
  input  logic [DATA_W-1:0] sw_data,
  output logic [7:0]        led,
  output logic [7:0]        seg,
  output logic              busy
);

  localparam int CNT_W = $clog2(2 * BLINK_HALF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BLINK_HALF);

  logic              sync1, sync2, sync3;
  logic              step_pulse;
  state_t            state, next_state;
  logic [DATA_W-1:0] a_reg, b_reg;
  logic [DATA_W:0]   sum;
  logic [CNT_W-1:0]  blink_cnt;
  logic              dp;
  logic [3:0]        hex_in;
  logic [6:0]        hex_segs;
  logic [7:0]        led_nxt, seg_nxt;

  // Two flops resolve metastability; the third gives one pulse per press however long it is held.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= step;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign step_pulse = sync2 & ~sync3;

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:   if (step_pulse) next_state = S_HAVE_A;
        S_HAVE_A: if (step_pulse) next_state = S_ADD;
        S_ADD:    next_state = S_SHOW;
        S_SHOW:   if (step_pulse) next_state = acc_mode ? S_HAVE_A : S_IDLE;
      endcase
    end
  end

  // In accumulate mode the carry is dropped when the sum is chained back in as A.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      sum   <= '0;
    end else if (clear) begin
      a_reg <= '0;
      b_reg <= '0;
      sum   <= '0;
    end else begin
      unique case (state)
        S_IDLE:   if (step_pulse) a_reg <= sw_data;
        S_HAVE_A: if (step_pulse) b_reg <= sw_data;
        S_ADD:    sum <= {1'b0, a_reg} + {1'b0, b_reg};
        S_SHOW:   if (step_pulse && acc_mode) a_reg <= sum[DATA_W-1:0];
      endcase
    end
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n)
      blink_cnt <= '0;
    else if (state == S_SHOW && next_state == S_SHOW)
      blink_cnt <= (blink_cnt == CNT_LAST) ? '0 : blink_cnt + 1'b1;
    else
      blink_cnt <= '0;
  end

  assign dp     = sum[DATA_W] & (blink_cnt < CNT_HALF);
  assign hex_in = (state == S_SHOW) ? sum[3:0] : sw_data[3:0];

  hex7seg u_hex7seg (
    .digit (hex_in),
    .segs  (hex_segs)
  );

  // Outside S_SHOW the digit previews the switches; S_ADD keeps the previous LED value.
  always_comb begin
    led_nxt = {1'b0, state, 5'd0};
    seg_nxt = {1'b0, hex_segs};
    unique case (state)
      S_IDLE:   led_nxt = {1'b0, state, 5'd0};
      S_HAVE_A: led_nxt = {1'b0, state, 1'b0, a_reg};
      S_ADD:    led_nxt = {1'b0, state, led[4:0]};
      S_SHOW: begin
        led_nxt = {sum[DATA_W], state, sum};
        seg_nxt = {dp, hex_segs};
      end
    endcase
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      led  <= 8'h00;
      seg  <= 8'h00;
      busy <= 1'b0;
    end else begin
      led  <= led_nxt;
      seg  <= seg_nxt;
      busy <= (state == S_ADD);
    end
  end

endmodule

// File: tb/tb_soma_seq_ctrl.sv
// Directed scoreboard bench for soma_seq_ctrl: expectations are queued as stimulus is
// applied and popped when the corresponding registered output is observed.
module tb_soma_seq_ctrl;

  logic       clk_2;
  logic       rst_n;
  logic       step;
  logic       clear;
  logic       acc_mode;
  logic [3:0] sw_data;
  logic [7:0] led;
  logic [7:0] seg;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] led;
    logic [7:0] seg;
    logic       busy;
  } exp_t;

  exp_t sb[$];

  soma_seq_ctrl #(.DATA_W(4), .BLINK_HALF(8)) dut (
    .clk_2    (clk_2),
    .rst_n    (rst_n),
    .step     (step),
    .clear    (clear),
    .acc_mode (acc_mode),
    .sw_data  (sw_data),
    .led      (led),
    .seg      (seg),
    .busy     (busy)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] hexRef(input logic [3:0] v);
    case (v)
      4'h0: hexRef = 7'h3F;  4'h1: hexRef = 7'h06;
      4'h2: hexRef = 7'h5B;  4'h3: hexRef = 7'h4F;
      4'h4: hexRef = 7'h66;  4'h5: hexRef = 7'h6D;
      4'h6: hexRef = 7'h7D;  4'h7: hexRef = 7'h07;
      4'h8: hexRef = 7'h7F;  4'h9: hexRef = 7'h6F;
      4'hA: hexRef = 7'h77;  4'hB: hexRef = 7'h7C;
      4'hC: hexRef = 7'h39;  4'hD: hexRef = 7'h5E;
      4'hE: hexRef = 7'h79;  default: hexRef = 7'h71;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  task automatic applyStimulus(input logic [3:0] sw, input logic acc, input logic clr);
    sw_data  = sw;
    acc_mode = acc;
    clear    = clr;
  endtask

  task automatic pushExpect(input string tag, input logic [7:0] l, input logic [7:0] s,
                            input logic b);
    exp_t e;
    e.tag  = tag;
    e.led  = l;
    e.seg  = s;
    e.busy = b;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty: observed size 0, expected nonzero");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (led === e.led) else begin
        errors++;
        $error("[TB] FAIL %s led: observed %02h expected %02h", e.tag, led, e.led);
      end
      checks++;
      assert (seg === e.seg) else begin
        errors++;
        $error("[TB] FAIL %s seg: observed %02h expected %02h", e.tag, seg, e.seg);
      end
      checks++;
      assert (busy === e.busy) else begin
        errors++;
        $error("[TB] FAIL %s busy: observed %0b expected %0b", e.tag, busy, e.busy);
      end
    end
  endtask

  // Polls each cycle so the caller lands on the first cycle the new state code appears.
  task automatic waitCode(input string tag, input logic [1:0] code, input int max_cycles);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk_2);
      if (led[6:5] === code) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("[TB] FAIL %s wait: observed code %0d expected %0d within %0d cycles",
             tag, led[6:5], code, max_cycles);
    end
  endtask

  task automatic pressButton();
    step = 1'b1;
    tick(2);
    step = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    step  = 1'b0;
    applyStimulus(4'd5, 1'b0, 1'b0);
    #2;
    pushExpect("in_reset", 8'h00, 8'h00, 1'b0);
    checkOutput();
    tick(1);
    rst_n = 1'b1;
    tick(1);
    pushExpect("idle_preview", 8'h00, {1'b0, hexRef(4'd5)}, 1'b0);
    checkOutput();

    $display("[TB] basic add 3+4");
    applyStimulus(4'd3, 1'b0, 1'b0);
    pressButton();
    waitCode("add_have_a", 2'd1, 10);
    pushExpect("add_have_a", 8'h23, {1'b0, hexRef(4'd3)}, 1'b0);
    checkOutput();
    applyStimulus(4'd4, 1'b0, 1'b0);
    pressButton();
    waitCode("add_busy", 2'd2, 10);
    pushExpect("add_busy", 8'h43, {1'b0, hexRef(4'd4)}, 1'b1);
    checkOutput();
    tick(1);
    pushExpect("add_show", 8'h67, 8'h07, 1'b0);
    checkOutput();
    tick(3);
    pushExpect("add_show_hold", 8'h67, 8'h07, 1'b0);
    checkOutput();
    pressButton();
    waitCode("add_back_idle", 2'd0, 10);
    pushExpect("add_back_idle", 8'h00, {1'b0, hexRef(4'd4)}, 1'b0);
    checkOutput();

    $display("[TB] overflow blink 9+8");
    applyStimulus(4'd9, 1'b0, 1'b0);
    pressButton();
    waitCode("ovf_have_a", 2'd1, 10);
    pushExpect("ovf_have_a", 8'h29, {1'b0, hexRef(4'd9)}, 1'b0);
    checkOutput();
    applyStimulus(4'd8, 1'b0, 1'b0);
    pressButton();
    waitCode("ovf_busy", 2'd2, 10);
    pushExpect("ovf_busy", 8'h49, {1'b0, hexRef(4'd8)}, 1'b1);
    checkOutput();
    for (int i = 0; i < 17; i++) begin
      tick(1);
      pushExpect($sformatf("ovf_blink%0d", i), 8'hF1, ((i % 16) < 8) ? 8'h86 : 8'h06, 1'b0);
      checkOutput();
    end
    pressButton();
    waitCode("ovf_back_idle", 2'd0, 10);

    $display("[TB] accumulate 7+6 then +2");
    applyStimulus(4'd7, 1'b1, 1'b0);
    pressButton();
    waitCode("acc_have_a", 2'd1, 10);
    applyStimulus(4'd6, 1'b1, 1'b0);
    pressButton();
    waitCode("acc_busy", 2'd2, 10);
    tick(1);
    pushExpect("acc_show13", 8'h6D, {1'b0, hexRef(4'hD)}, 1'b0);
    checkOutput();
    pressButton();
    waitCode("acc_chain", 2'd1, 10);
    pushExpect("acc_chain", 8'h2D, {1'b0, hexRef(4'd6)}, 1'b0);
    checkOutput();
    applyStimulus(4'd2, 1'b1, 1'b0);
    pressButton();
    waitCode("acc_busy2", 2'd2, 10);
    pushExpect("acc_busy2", 8'h4D, {1'b0, hexRef(4'd2)}, 1'b1);
    checkOutput();
    tick(1);
    pushExpect("acc_show15", 8'h6F, 8'h71, 1'b0);
    checkOutput();
    applyStimulus(4'd2, 1'b0, 1'b0);
    pressButton();
    waitCode("acc_back_idle", 2'd0, 10);

    $display("[TB] clear coincident with step pulse");
    applyStimulus(4'd5, 1'b0, 1'b0);
    pressButton();
    waitCode("clr_have_a", 2'd1, 10);
    pushExpect("clr_have_a", 8'h25, {1'b0, hexRef(4'd5)}, 1'b0);
    checkOutput();
    step = 1'b1;
    tick(2);
    applyStimulus(4'd5, 1'b0, 1'b1);
    tick(1);
    applyStimulus(4'd5, 1'b0, 1'b0);
    step = 1'b0;
    tick(1);
    pushExpect("clr_idle", 8'h00, {1'b0, hexRef(4'd5)}, 1'b0);
    checkOutput();
    tick(5);
    pushExpect("clr_stays_idle", 8'h00, {1'b0, hexRef(4'd5)}, 1'b0);
    checkOutput();

    $display("[TB] held button gives one transition");
    applyStimulus(4'd1, 1'b0, 1'b0);
    step = 1'b1;
    tick(20);
    step = 1'b0;
    tick(5);
    pushExpect("hold_one_step", 8'h21, {1'b0, hexRef(4'd1)}, 1'b0);
    checkOutput();

    $display("[TB] async reset during show");
    applyStimulus(4'd2, 1'b0, 1'b0);
    pressButton();
    waitCode("rst_busy", 2'd2, 10);
    tick(1);
    pushExpect("rst_show", 8'h63, {1'b0, hexRef(4'd3)}, 1'b0);
    checkOutput();
    #2;
    rst_n = 1'b0;
    #1;
    pushExpect("rst_async", 8'h00, 8'h00, 1'b0);
    checkOutput();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    pushExpect("rst_idle", 8'h00, {1'b0, hexRef(4'd2)}, 1'b0);
    checkOutput();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_leftover: observed %0d entries, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
